// File: rtl/aes_axis_pkg.sv
// Shared constants and types for the AES3 AXI4-Stream receive path.
package aes_axis_pkg;

   // Preamble codes carried in tdata[3:0]
   localparam logic [3:0] PRE_B = 4'h1;  // ch0, frame 0 of a block
   localparam logic [3:0] PRE_M = 4'h2;  // ch0, frames 1..191
   localparam logic [3:0] PRE_W = 4'h3;  // ch1, every frame

   // Subframe field positions
   localparam int PRE_MSB    = 3;
   localparam int SAMPLE_LSB = 4;
   localparam int SAMPLE_MSB = 27;
   localparam int C_BIT      = 30;

   // Channel-status block geometry
   localparam int FRAMES_PER_BLOCK = 192;
   localparam int FCNT_W           = $clog2(FRAMES_PER_BLOCK);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      EXP_CH0 = 2'd1,
      EXP_CH1 = 2'd2
   } state_e;

endpackage

// File: rtl/aes_cs_collector.sv
// Channel-status collector: builds a 192-bit block one C bit per frame and
// publishes it only when the whole block has been received.
module aes_cs_collector
   import aes_axis_pkg::*;
(
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        clr_i,
   input  logic                        wr_i,
   input  logic [FCNT_W-1:0]           idx_i,
   input  logic                        bit_i,
   input  logic                        commit_i,
   output logic [FRAMES_PER_BLOCK-1:0] block_o,
   output logic                        valid_o
);

   logic [FRAMES_PER_BLOCK-1:0] cap_q, cap_d;
   logic [FRAMES_PER_BLOCK-1:0] block_q;
   logic                        valid_q;

   // Next capture contents: merge this cycle's write so a commit sees bit 191
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      cap_d = cap_q;
      if (wr_i) begin
         cap_d[idx_i] = bit_i;
      end
      if (clr_i) begin
         cap_d = '0;
      end
   end

   // Capture register: every index is rewritten before any commit, so no reset
   always_ff @(posedge clk) begin
      // NOTE: working storage that is fully overwritten before use is left unreset; only
      // externally visible state is reset.
      cap_q <= cap_d;
   end

   // Published block and its one-cycle update strobe
   always_ff @(posedge clk) begin
      if (!resetn) begin
         block_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= commit_i;
         if (commit_i) begin
            block_q <= cap_d;
         end
      end
   end

   assign block_o = block_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/aes_axis_sink.sv
// AES3 subframe sink: locks to the B/M/W preamble sequence, publishes one
// stereo pair per frame, gathers channel status and counts framing errors.
module aes_axis_sink
   import aes_axis_pkg::*;
#(
   parameter int SAMPLE_W = 24,
   parameter int ERR_W    = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        s_axis_audio_tvalid,
   output logic                        s_axis_audio_tready,
   input  logic [2:0]                  s_axis_audio_tid,
   input  logic [31:0]                 s_axis_audio_tdata,
   output logic [SAMPLE_W-1:0]         sample_ch0,
   output logic [SAMPLE_W-1:0]         sample_ch1,
   output logic                        frame_valid,
   output logic [FRAMES_PER_BLOCK-1:0] cs_block,
   output logic                        cs_valid,
   output logic                        lock,
   output logic                        sync_err,
   output logic [ERR_W-1:0]            err_count
);

   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_BLOCK - 1);
   localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
   localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);

   state_e                state_q;
   logic [FCNT_W-1:0]     fcnt_q;
   logic                  tready_q;
   logic                  lock_q;
   logic [SAMPLE_W-1:0]   stage_sample_q;
   logic                  stage_c_q;
   logic [SAMPLE_W-1:0]   sample_ch0_q, sample_ch1_q;
   logic                  frame_valid_q;
   logic                  sync_err_q;
   logic [ERR_W-1:0]      err_count_q;

   logic                  beat;
   logic [3:0]            pre;
   logic [SAMPLE_W-1:0]   smp;
   logic                  c_bit;
   logic                  is_b_ch0, ch0_ok, ch1_ok;
   logic                  mismatch, acquire, publish, commit;

   // V, U, P and the ch1 C bit carry nothing this block uses
   logic                  unused_bits;
   assign unused_bits = ^{s_axis_audio_tdata[31], s_axis_audio_tdata[29:28]};

   assign beat     = s_axis_audio_tvalid && tready_q;
   assign pre      = s_axis_audio_tdata[PRE_MSB:0];
   assign smp      = s_axis_audio_tdata[SAMPLE_MSB:SAMPLE_LSB];
   assign c_bit    = s_axis_audio_tdata[C_BIT];
   assign is_b_ch0 = (s_axis_audio_tid == 3'd0) && (pre == PRE_B);
   assign ch0_ok   = (s_axis_audio_tid == 3'd0) &&
                     (pre == ((fcnt_q == '0) ? PRE_B : PRE_M));
   assign ch1_ok   = (s_axis_audio_tid == 3'd1) && (pre == PRE_W);

   // Classify the accepted beat against what the current state expects
   always_comb begin
      mismatch = 1'b0;
      unique case (state_q)
         EXP_CH0: mismatch = beat && !ch0_ok;
         EXP_CH1: mismatch = beat && !ch1_ok;
         default: mismatch = 1'b0;
      endcase
      // A B/tid0 beat restarts frame 0 whether hunting or breaking sync
      acquire = beat && is_b_ch0 && ((state_q == HUNT) || mismatch);
      publish = beat && (state_q == EXP_CH1) && ch1_ok;
      commit  = publish && (fcnt_q == FCNT_LAST);
   end

   // Framing FSM with registered outputs
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!resetn) begin
         state_q        <= HUNT;
         fcnt_q         <= '0;
         tready_q       <= 1'b0;
         lock_q         <= 1'b0;
         stage_sample_q <= '0;
         stage_c_q      <= 1'b0;
         sample_ch0_q   <= '0;
         sample_ch1_q   <= '0;
         frame_valid_q  <= 1'b0;
         sync_err_q     <= 1'b0;
         err_count_q    <= '0;
      end else begin
         tready_q      <= 1'b1;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         if (mismatch) begin
            sync_err_q <= 1'b1;
            if (err_count_q != '1) begin
               err_count_q <= err_count_q + ERR_ONE;
            end
            state_q <= HUNT;
            lock_q  <= 1'b0;
         end
         if (acquire) begin
            state_q        <= EXP_CH1;
            lock_q         <= 1'b1;
            fcnt_q         <= '0;
            stage_sample_q <= smp;
            stage_c_q      <= c_bit;
         end else if (beat && !mismatch) begin
            unique case (state_q)
               EXP_CH0: begin
                  stage_sample_q <= smp;
                  stage_c_q      <= c_bit;
                  state_q        <= EXP_CH1;
               end
               EXP_CH1: begin
                  sample_ch0_q  <= stage_sample_q;
                  sample_ch1_q  <= smp;
                  frame_valid_q <= 1'b1;
                  fcnt_q        <= (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCNT_ONE;
                  state_q       <= EXP_CH0;
               end
               default: ;
            endcase
         end
      end
   end

   aes_cs_collector u_cs (
      .clk      (clk),
      .resetn   (resetn),
      .clr_i    (mismatch),
      .wr_i     (publish),
      .idx_i    (fcnt_q),
      .bit_i    (stage_c_q),
      .commit_i (commit),
      .block_o  (cs_block),
      .valid_o  (cs_valid)
   );

   assign s_axis_audio_tready = tready_q;
   assign sample_ch0          = sample_ch0_q;
   assign sample_ch1          = sample_ch1_q;
   assign frame_valid         = frame_valid_q;
   assign lock                = lock_q;
   assign sync_err            = sync_err_q;
   assign err_count           = err_count_q;

endmodule
